mcu_spi_target: RTL
===================

// Module: mcu_spi_target
// PURPOSE
// - SPI target between the external MCU and the FPGA control blocks; sits directly upstream of sysctrl.
// - Deserialises MOSI bytes and routes them to one of four targets: sys, hid, osd or sdc.
// - Serialises each target's response byte onto MISO.
// - First byte of each SS-low frame selects the target. The second byte is presented with start=1 (command byte).
// PARAMETERS
// - SYNC_STAGES     2      flip-flop stages in the ss/sck/mosi synchronisers (min 2)
// - TIMEOUT_CYCLES  65535  clk cycles without an SCK edge before a frame aborts (only with MCU_SPI_TIMEOUT_EN)
// PORTS
// - clk             in   1  system clock; all logic in this domain
// - reset           in   1  asynchronous, active-high reset
// - spi_io_ss       in   1  frame select, active low (async to clk)
// - spi_io_clk      in   1  SPI clock, mode 0: sample on rise, shift on fall (async to clk)
// - spi_io_din      in   1  MOSI
// - spi_io_dout     out  1  MISO
// - mcu_sys_strobe  out  1  one-clk pulse: mcu_dout valid for target 0 (sys)
// - mcu_hid_strobe  out  1  same, target 1 (hid)
// - mcu_osd_strobe  out  1  same, target 2 (osd)
// - mcu_sdc_strobe  out  1  same, target 3 (sdc)
// - mcu_start       out  1  high with a strobe when the byte is the first after the target byte
// - mcu_dout        out  8  received byte; held until the next strobe
// - mcu_sys_din     in   8  response byte from sys
// - mcu_hid_din     in   8  response byte from hid
// - mcu_osd_din     in   8  response byte from osd
// - mcu_sdc_din     in   8  response byte from sdc
// BEHAVIOUR
// - Reset values: all strobes 0, mcu_start 0, mcu_dout 8'h00, spi_io_dout 0.
//   Internal: state SKIP, bit counter 0, tx shift register 8'h00.
// - Synchronisation:
//   - ss, sck and mosi each pass through SYNC_STAGES flip-flops.
//   - SCK rise and fall are detected on the synchronised signals.
//   - Requirement: SCK high and low phases are each >= SYNC_STAGES+2 clk cycles.
// - Receive path:
//   - On each SCK rise, rx <= {rx[6:0], mosi} (MSB first) and the 3-bit bit counter increments.
//   - On the 8th rise (count wraps 7->0) the byte completes.
//   - Strobes and mcu_start assert on the cycle after the rise is detected, for exactly 1 clk.
//   - Latency from the synchronised 8th rise to the strobe is 1 clk.
// - States:
//   - IDLE: ss high. Counter 0, MISO 0. ss low -> TARGET.
//   - TARGET: on byte complete, latch target = byte[1:0] and go to CMD if byte <= 3, otherwise SKIP. No strobe.
//   - CMD: on byte complete, pulse the selected strobe with mcu_start=1 and go to DATA.
//   - DATA: on byte complete, pulse the selected strobe with mcu_start=0 and stay in DATA.
//   - SKIP: ignore all bytes; MISO 0. Exit to IDLE only when ss is high.
//   - ss high (synchronised) in any state -> IDLE next cycle. Any partial byte is discarded with no strobe.
//   - If ss rises in the same cycle as the 8th SCK rise, ss wins: no strobe.
// - Transmit path:
//   - On each SCK fall, tx <= {tx[6:0],1'b0}. spi_io_dout = tx[7], registered.
//   - On the SCK fall that follows a byte completion, tx loads the selected target's din instead of shifting.
//     The target has by then registered its reply to the strobe.
//   - In TARGET, SKIP and IDLE, tx loads 8'h00.
//   - The first byte of a frame always returns 8'h00 on MISO.
// - After reset deasserts with ss already low, the block stays in SKIP until ss goes high. A mid-frame reset never produces a partial strobe.
// - mcu_dout changes only when a strobe asserts.
// CONFIGURATION
// - Macro MCU_SPI_TIMEOUT_EN defined:
//   - A 16-bit counter clears on every SCK edge and on ss high, and counts while ss is low in TARGET, CMD or DATA.
//   - When it reaches TIMEOUT_CYCLES the block enters SKIP without issuing a strobe.
// - Macro MCU_SPI_TIMEOUT_EN undefined: no counter; a frame lasts until ss rises.
// TESTING
// - Frame 00 00 xx xx xx (sys, cmd 0), sys_din echoes 5c/42/02 -> sys_strobe x4; start=1 on the cmd byte only; MISO 00 00 5c 42 02.
// - Frame 02 07 AA -> osd_strobe x2 with mcu_dout 07 then AA; start only on 07; other strobes stay 0.
// - Frame 05 11 22 (invalid target) -> no strobes; MISO all 00. Next frame 01 03 -> hid_strobe with start=1, dout 03.
// - ss rises after 5 bits of the 3rd byte -> no 3rd strobe. Next frame works normally: bit counter restarted at 0.
// - Assert reset mid-byte with ss low, then release -> outputs return to reset values immediately. Rest of the frame ignored; the following frame is decoded.
// - With MCU_SPI_TIMEOUT_EN and TIMEOUT_CYCLES=100: stall SCK 150 clk mid-frame -> SKIP, no strobe; after ss high the next frame decodes. Without the macro the frame resumes.

Source files
------------

// File: rtl/mcu_spi_target.sv
// mcu_spi_target: SPI mode-0 target that routes MCU bytes to sys/hid/osd/sdc.
// The first byte of a frame selects the target and the second byte is flagged
// as the command byte. The reply byte of the selected target is shifted back
// on MISO.
// Optional feature: define MCU_SPI_TIMEOUT_EN to abort a frame when SCK stalls
// for TIMEOUT_CYCLES clk cycles.
module mcu_spi_target #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_io_ss,
  input  logic       spi_io_clk,
  input  logic       spi_io_din,
  output logic       spi_io_dout,
  output logic       mcu_sys_strobe,
  output logic       mcu_hid_strobe,
  output logic       mcu_osd_strobe,
  output logic       mcu_sdc_strobe,
  output logic       mcu_start,
  output logic [7:0] mcu_dout,
  input  logic [7:0] mcu_sys_din,
  input  logic [7:0] mcu_hid_din,
  input  logic [7:0] mcu_osd_din,
  input  logic [7:0] mcu_sdc_din
);

  typedef enum logic [2:0] {S_IDLE, S_TARGET, S_CMD, S_DATA, S_SKIP} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] ss_sr, sck_sr, mosi_sr;
  logic                   ss_s, sck_s, mosi_s, sck_d;
  logic                   rise, fall, done, issue, active, tmo_hit;
  logic [2:0]             cnt;
  logic [7:0]             rx, byte_in, tx, din_sel;
  logic [1:0]             tgt;
  logic [3:0]             strb;
  logic                   pend;

  // Synchronisers. ss resets low so a frame already in progress at reset
  // release is held in SKIP until the MCU raises ss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_sr   <= '0;
      sck_sr  <= '0;
      mosi_sr <= '0;
      sck_d   <= 1'b0;
    end else begin
      ss_sr   <= {ss_sr[SYNC_STAGES-2:0], spi_io_ss};
      sck_sr  <= {sck_sr[SYNC_STAGES-2:0], spi_io_clk};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_io_din};
      sck_d   <= sck_sr[SYNC_STAGES-1];
    end
  end

  assign ss_s    = ss_sr[SYNC_STAGES-1];
  assign sck_s   = sck_sr[SYNC_STAGES-1];
  assign mosi_s  = mosi_sr[SYNC_STAGES-1];
  assign rise    = sck_s & ~sck_d;
  assign fall    = ~sck_s & sck_d;
  assign byte_in = {rx[6:0], mosi_s};
  assign done    = rise && (cnt == 3'd7) && !ss_s;
  assign active  = (state == S_TARGET) || (state == S_CMD) || (state == S_DATA);

`ifdef MCU_SPI_TIMEOUT_EN
  logic [15:0] tmo;

  // Stall counter: cleared by any SCK edge or ss high, runs only mid-frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    tmo <= '0;
    else if (ss_s || rise || fall) tmo <= '0;
    else if (active)               tmo <= tmo + 16'd1;
    else                           tmo <= '0;
  end

  assign tmo_hit = active && (tmo == 16'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
`endif

  // Receive shift register and bit counter; ss high discards a partial byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx  <= '0;
      cnt <= '0;
    end else if (ss_s) begin
      cnt <= '0;
    end else if (rise) begin
      rx  <= byte_in;
      cnt <= cnt + 3'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_SKIP;
    else       state <= state_nxt;
  end

  // Next-state logic; ss high takes priority over a byte completing.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    if (ss_s) begin
      state_nxt = S_IDLE;
    end else if (tmo_hit) begin
      state_nxt = S_SKIP;
    end else begin
      case (state)
        S_IDLE:   state_nxt = S_TARGET;
        S_TARGET: if (done) state_nxt = (byte_in <= 8'd3) ? S_CMD : S_SKIP;
        S_CMD:    if (done) begin state_nxt = S_DATA; issue = 1'b1; end
        S_DATA:   if (done) issue = 1'b1;
        default:  state_nxt = state;
      endcase
    end
  end

  // Target latch, strobes, start flag and received byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt       <= '0;
      strb      <= '0;
      mcu_start <= 1'b0;
      mcu_dout  <= '0;
    end else begin
      if (state == S_TARGET && state_nxt == S_CMD) tgt <= byte_in[1:0];
      strb      <= issue ? (4'd1 << tgt) : 4'd0;
      mcu_start <= issue && (state == S_CMD);
      if (issue) mcu_dout <= byte_in;
    end
  end

  assign mcu_sys_strobe = strb[0];
  assign mcu_hid_strobe = strb[1];
  assign mcu_osd_strobe = strb[2];
  assign mcu_sdc_strobe = strb[3];

  // Reply mux for the currently selected target.
  always_comb begin
    din_sel = mcu_sys_din;
    case (tgt)
      2'd1:    din_sel = mcu_hid_din;
      2'd2:    din_sel = mcu_osd_din;
      2'd3:    din_sel = mcu_sdc_din;
      default: din_sel = mcu_sys_din;
    endcase
  end

  // Transmit shifter: after a strobed byte the next SCK fall loads the
  // target's reply, giving the target several clks to register it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx   <= '0;
      pend <= 1'b0;
    end else if (ss_s || state == S_IDLE || state == S_SKIP) begin
      tx   <= '0;
      pend <= 1'b0;
    end else begin
      if (issue) pend <= 1'b1;
      if (fall) begin
        pend <= 1'b0;
        if (pend)                   tx <= din_sel;
        else if (state == S_TARGET) tx <= '0;
        else                        tx <= {tx[6:0], 1'b0};
      end
    end
  end

  assign spi_io_dout = tx[7];

endmodule
